// File: rtl/swervolf_sevseg_ctrl.sv
// Wishbone-mapped N-digit seven-segment scan controller.
// Supports hex-decode and raw segment modes, decimal points, a per-digit mask,
// PWM brightness, blanking between digits, shadow registers that can be held
// until a frame boundary, and a frame-done interrupt.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_wb_*               Wishbone slave (word index = i_wb_adr[5:2])
//   o_wb_rdt, o_wb_ack   registered read data, single-cycle ack
//   o_irq                frame-done interrupt (level)
//   o_an, o_seg, o_dp    anodes, segments a..g (bit0..6), decimal point; all active low
module swervolf_sevseg_ctrl #(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 64,
  parameter int unsigned PWM_BITS    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [5:0]          i_wb_adr,
  input  logic [31:0]         i_wb_dat,
  input  logic [3:0]          i_wb_sel,
  input  logic                i_wb_we,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  output logic [31:0]         o_wb_rdt,
  output logic                o_wb_ack,
  output logic                o_irq,
  output logic [N_DIGITS-1:0] o_an,
  output logic [6:0]          o_seg,
  output logic                o_dp
);

  localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);
  localparam int unsigned BR_W    = PWM_BITS + 1;

  localparam logic [BR_W-1:0]    BR_MAX     = BR_W'(1 << PWM_BITS);
  localparam logic [2:0]         LAST_IDX   = 3'(N_DIGITS - 1);
  localparam logic [PRESC_W-1:0] LAST_PRESC = PRESC_W'(REFRESH_DIV - 1);

  localparam logic [3:0] A_CTRL   = 4'd0;
  localparam logic [3:0] A_BRIGHT = 4'd1;
  localparam logic [3:0] A_HEX    = 4'd2;
  localparam logic [3:0] A_DP     = 4'd3;
  localparam logic [3:0] A_RAW_LO = 4'd4;
  localparam logic [3:0] A_RAW_HI = 4'd5;
  localparam logic [3:0] A_STATUS = 4'd6;
  localparam logic [3:0] A_ID     = 4'd7;

  // Byte-lane merge of a write into an existing 32-bit value
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // Hex nibble to segment pattern, lit = 1
  function automatic logic [6:0] hexdec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic                ctrl_en, ctrl_raw, ctrl_sync, ctrl_irq_en;
  logic [7:0]          mask_s, mask_a;
  logic [BR_W-1:0]     bright_s, bright_a;
  logic [31:0]         hex_s, hex_a;
  logic [7:0]          dp_s, dp_a;
  logic [63:0]         raw_s;
  logic [7:0][6:0]     raw_a;
  logic [PRESC_W-1:0]  presc;
  logic [2:0]          idx;
  logic [7:0]          frame_cnt;
  logic [PWM_BITS-1:0] pwm;

  logic        acc_c, wr_c, slot_end_c, frame_wrap_c, copy_c, irq_clr_c;
  logic        unblank_c, lit_c;
  logic [3:0]  word_c;
  logic [31:0] rd_c, bright_m_c;
  logic [BR_W-1:0]     bright_sat_c;
  logic [N_DIGITS-1:0] an_c;
  logic [6:0]  seg_pat_c;
  logic        unused_c;

  assign acc_c    = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr_c     = acc_c & i_wb_we;
  assign word_c   = i_wb_adr[5:2];
  assign unused_c = &{1'b0, i_wb_adr[1:0]};

  // Brightness write saturates at full duty
  assign bright_m_c   = merge_bytes(32'(bright_s), i_wb_dat, i_wb_sel);
  assign bright_sat_c = (bright_m_c > 32'(BR_MAX)) ? BR_MAX : bright_m_c[BR_W-1:0];

  assign slot_end_c   = (presc == LAST_PRESC);
  assign frame_wrap_c = ctrl_en & slot_end_c & (idx == LAST_IDX);
  // Shadow copy: every cycle when not synchronised, else only on frame wrap
  assign copy_c       = ctrl_sync ? frame_wrap_c : 1'b1;
  assign irq_clr_c    = wr_c & (word_c == A_STATUS) & i_wb_sel[2] & i_wb_dat[16];

  // Register read mux
  always_comb begin
    rd_c = 32'b0;
    case (word_c)
      A_CTRL:   rd_c = {16'b0, mask_s, 4'b0, ctrl_irq_en, ctrl_sync, ctrl_raw, ctrl_en};
      A_BRIGHT: rd_c = 32'(bright_s);
      A_HEX:    rd_c = hex_s;
      A_DP:     rd_c = {24'b0, dp_s};
      A_RAW_LO: rd_c = raw_s[31:0];
      A_RAW_HI: rd_c = raw_s[63:32];
      A_STATUS: rd_c = {15'b0, o_irq, frame_cnt, 5'b0, idx};
      A_ID:     rd_c = 32'(N_DIGITS);
      default:  rd_c = 32'b0;
    endcase
  end

  // Bus handshake and shadow register writes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_ack    <= 1'b0;
      o_wb_rdt    <= 32'b0;
      ctrl_en     <= 1'b0;
      ctrl_raw    <= 1'b0;
      ctrl_sync   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      mask_s      <= 8'hFF;
      bright_s    <= BR_MAX;
      hex_s       <= 32'b0;
      dp_s        <= 8'b0;
      raw_s       <= 64'b0;
    end else begin
      o_wb_ack <= acc_c;
      if (acc_c) o_wb_rdt <= rd_c;
      if (wr_c) begin
        case (word_c)
          A_CTRL: begin
            if (i_wb_sel[0]) {ctrl_irq_en, ctrl_sync, ctrl_raw, ctrl_en} <= i_wb_dat[3:0];
            if (i_wb_sel[1]) mask_s <= i_wb_dat[15:8];
          end
          A_BRIGHT: bright_s <= bright_sat_c;
          A_HEX:    hex_s <= merge_bytes(hex_s, i_wb_dat, i_wb_sel);
          A_DP:     if (i_wb_sel[0]) dp_s <= i_wb_dat[7:0];
          A_RAW_LO: raw_s[31:0]  <= merge_bytes(raw_s[31:0], i_wb_dat, i_wb_sel);
          A_RAW_HI: raw_s[63:32] <= merge_bytes(raw_s[63:32], i_wb_dat, i_wb_sel);
          default: ;
        endcase
      end
    end
  end

  // Active copies used by the scanner
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_a   <= 8'hFF;
      bright_a <= BR_MAX;
      hex_a    <= 32'b0;
      dp_a     <= 8'b0;
      raw_a    <= '0;
    end else if (copy_c) begin
      mask_a   <= mask_s;
      bright_a <= bright_s;
      hex_a    <= hex_s;
      dp_a     <= dp_s;
      for (int k = 0; k < 8; k++) raw_a[k] <= raw_s[8*k +: 7];
    end
  end

  // Prescaler, digit index, PWM counter and frame counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc     <= '0;
      idx       <= 3'd0;
      pwm       <= '0;
      frame_cnt <= 8'd0;
    end else begin
      if (!ctrl_en) begin
        presc <= '0;
        idx   <= 3'd0;
        pwm   <= '0;
      end else begin
        presc <= slot_end_c ? '0 : presc + PRESC_W'(1);
        pwm   <= pwm + PWM_BITS'(1);
        if (slot_end_c) idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
      end
      if (frame_wrap_c) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Frame-done flag; a set in the same cycle as a clear wins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        o_irq <= 1'b0;
    else if (frame_wrap_c & ctrl_irq_en) o_irq <= 1'b1;
    else if (irq_clr_c)                  o_irq <= 1'b0;
  end

  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign unblank_c = 1'b1;
    end else begin : g_blank
      assign unblank_c = (presc >= PRESC_W'(BLANK_CYC));
    end
  endgenerate

  assign lit_c = ctrl_en & mask_a[idx] & unblank_c & ({1'b0, pwm} < bright_a);

  // Anode and segment pattern for the current slot
  always_comb begin
    an_c = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (lit_c && (idx == 3'(k))) an_c[k] = 1'b0;
    end
    seg_pat_c = ctrl_raw ? raw_a[idx] : hexdec(hex_a[{idx, 2'b00} +: 4]);
  end

  // Display outputs; dark whenever scanning is disabled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_an  <= '1;
      o_seg <= 7'h7F;
      o_dp  <= 1'b1;
    end else if (!ctrl_en) begin
      o_an  <= '1;
      o_seg <= 7'h7F;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= an_c;
      o_seg <= ~seg_pat_c;
      o_dp  <= ~dp_a[idx];
    end
  end

endmodule

// File: tb/tb_swervolf_sevseg_ctrl.sv
// Directed testbench for swervolf_sevseg_ctrl.
// u_dut: 8 digits, 4 cycles/slot, no blanking. u_dut_b: 8 cycles/slot, 2 blank cycles.
module tb_swervolf_sevseg_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;

  logic [31:0] rdt_a, rdt_b;
  logic        ack_a, ack_b, irq_a, irq_b;
  logic [7:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;

  int checks;
  int failures;

  logic [6:0] hexlut [16];

  swervolf_sevseg_ctrl #(.N_DIGITS(8), .REFRESH_DIV(4), .BLANK_CYC(0), .PWM_BITS(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_rdt(rdt_a), .o_wb_ack(ack_a),
    .o_irq(irq_a), .o_an(an_a), .o_seg(seg_a), .o_dp(dp_a));

  swervolf_sevseg_ctrl #(.N_DIGITS(8), .REFRESH_DIV(8), .BLANK_CYC(2), .PWM_BITS(4)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_rdt(rdt_b), .o_wb_ack(ack_b),
    .o_irq(irq_b), .o_an(an_b), .o_seg(seg_b), .o_dp(dp_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    adr = a; dat = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    adr = a; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    d = rdt_a;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic [5:0] addrs [6];
    logic [31:0] exps [6];
    addrs = '{6'h00, 6'h04, 6'h08, 6'h18, 6'h1C, 6'h20};
    exps  = '{32'h0000_FF00, 32'd16, 32'h0, 32'h0, 32'd8, 32'h0};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({an_a, seg_a, dp_a, ack_a, irq_a} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: an=%h seg=%h dp=%b ack=%b irq=%b, required an=ff seg=7f dp=1 ack=0 irq=0",
               an_a, seg_a, dp_a, ack_a, irq_a);
    end
    checks++;
    if (rdt_a !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdt: got %h required 0", rdt_a);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_read(addrs[i], r);
      checks++;
      if (r !== exps[i]) begin
        failures++;
        $display("FAIL reset_read adr=%h: got %h required %h", addrs[i], r, exps[i]);
      end
    end
  endtask

  task automatic test_hex_scan();
    logic [31:0] r;
    int d;
    bus_write(6'h08, 32'h7654_3210, 4'hF);
    bus_write(6'h00, 32'h1, 4'h1);
    @(negedge clk);
    checks++;
    if (an_a !== 8'hFF) begin
      failures++;
      $display("FAIL hex_first_cycle_dark: an=%h required ff", an_a);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      d = (k / 4) % 8;
      checks++;
      if (an_a !== ~(8'h01 << d) || seg_a !== ~hexlut[d]) begin
        failures++;
        $display("FAIL hex_scan k=%0d: an=%h seg=%h required an=%h seg=%h",
                 k, an_a, seg_a, ~(8'h01 << d), ~hexlut[d]);
      end
    end
    bus_read(6'h18, r);
    checks++;
    if (r !== 32'h0000_0102) begin
      failures++;
      $display("FAIL hex_status: got %h required 00000102", r);
    end
    bus_write(6'h00, 32'h0, 4'h1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (an_a !== 8'hFF || seg_a !== 7'h7F || dp_a !== 1'b1) begin
      failures++;
      $display("FAIL disable_dark: an=%h seg=%h dp=%b required ff 7f 1", an_a, seg_a, dp_a);
    end
    bus_read(6'h18, r);
    checks++;
    if (r !== 32'h0000_0100) begin
      failures++;
      $display("FAIL disable_status: got %h required 00000100", r);
    end
  endtask

  task automatic test_raw_dp();
    int d;
    bus_write(6'h10, 32'h0000_007F, 4'hF);
    bus_write(6'h14, 32'h0, 4'hF);
    bus_write(6'h0C, 32'h01, 4'hF);
    bus_write(6'h00, 32'h3, 4'h1);
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      d = k / 4;
      checks++;
      if (an_a !== ~(8'h01 << d) || seg_a !== ((d == 0) ? 7'h00 : 7'h7F) || dp_a !== (d != 0)) begin
        failures++;
        $display("FAIL raw_dp k=%0d: an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 k, an_a, seg_a, dp_a, ~(8'h01 << d), (d == 0) ? 7'h00 : 7'h7F, d != 0);
      end
    end
  endtask

  task automatic test_pwm();
    int lit;
    logic [31:0] r;
    logic [31:0] br [3];
    int exp_lit [3];
    br = '{32'd4, 32'd0, 32'd31};
    exp_lit = '{4, 0, 16};
    bus_write(6'h00, 32'h1, 4'h1);
    for (int i = 0; i < 3; i++) begin
      bus_write(6'h04, br[i], 4'hF);
      repeat (3) @(negedge clk);
      lit = 0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (an_a !== 8'hFF) lit++;
      end
      checks++;
      if (lit != exp_lit[i]) begin
        failures++;
        $display("FAIL pwm bright=%0d: lit cycles %0d of 16, required %0d", br[i], lit, exp_lit[i]);
      end
    end
    bus_read(6'h04, r);
    checks++;
    if (r !== 32'd16) begin
      failures++;
      $display("FAIL bright_saturate: read %0d required 16", r);
    end
  endtask

  task automatic test_mask();
    int lit, bad, max_idx;
    logic [31:0] r;
    bus_write(6'h00, 32'h0000_0F01, 4'h3);
    repeat (3) @(negedge clk);
    lit = 0;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (an_a !== 8'hFF) begin
        lit++;
        if (an_a[7:4] !== 4'hF) bad++;
      end
    end
    checks++;
    if (lit != 16 || bad != 0) begin
      failures++;
      $display("FAIL mask: lit=%0d masked_lit=%0d required 16 and 0", lit, bad);
    end
    max_idx = 0;
    for (int i = 0; i < 20; i++) begin
      bus_read(6'h18, r);
      if (int'(r[2:0]) > max_idx) max_idx = int'(r[2:0]);
    end
    checks++;
    if (max_idx != 7) begin
      failures++;
      $display("FAIL mask_idx_counts: max idx %0d required 7", max_idx);
    end
    bus_write(6'h00, 32'h0000_FF01, 4'h3);
  endtask

  task automatic test_sync_irq();
    int d, n;
    bit seen;
    logic [31:0] r;
    bus_write(6'h00, 32'h0000_FF00, 4'h3);
    bus_write(6'h00, 32'h4, 4'h1);
    bus_write(6'h00, 32'hD, 4'h1);
    repeat (6) @(negedge clk);
    bus_write(6'h08, 32'hFFFF_FFFF, 4'hF);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 64) begin
      @(negedge clk);
      n++;
      if (irq_a === 1'b1) begin
        seen = 1'b1;
      end else begin
        d = -1;
        for (int j = 0; j < 8; j++) if (an_a[j] === 1'b0) d = j;
        checks++;
        if (d < 0 || seg_a !== ~hexlut[d]) begin
          failures++;
          $display("FAIL sync_hold: an=%h seg=%h, old pattern required", an_a, seg_a);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL irq_timeout: o_irq=%b after 64 cycles, required 1", irq_a);
    end else begin
      checks++;
      if (an_a !== 8'h7F || seg_a !== 7'h78) begin
        failures++;
        $display("FAIL wrap_last_old: an=%h seg=%h required 7f 78", an_a, seg_a);
      end
      @(negedge clk);
      checks++;
      if (an_a !== 8'hFE || seg_a !== 7'h0E) begin
        failures++;
        $display("FAIL wrap_new_value: an=%h seg=%h required fe 0e", an_a, seg_a);
      end
      bus_read(6'h18, r);
      checks++;
      if (r[16] !== 1'b1) begin
        failures++;
        $display("FAIL status_irq_flag: bit16=%b required 1", r[16]);
      end
      bus_write(6'h18, 32'h0001_0000, 4'h4);
      checks++;
      if (irq_a !== 1'b0) begin
        failures++;
        $display("FAIL irq_w1c: o_irq=%b required 0", irq_a);
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #2;
    checks++;
    if (an_a === 8'hFF) begin
      failures++;
      $display("FAIL async_pre_lit: an=%h required a lit digit", an_a);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (an_a !== 8'hFF || seg_a !== 7'h7F || dp_a !== 1'b1 || an_b !== 8'hFF || seg_b !== 7'h7F) begin
      failures++;
      $display("FAIL async_reset: an=%h seg=%h dp=%b an_b=%h seg_b=%h required ff 7f 1 ff 7f",
               an_a, seg_a, dp_a, an_b, seg_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_blank();
    logic [7:0] exp_an;
    bus_write(6'h00, 32'h1, 4'h1);
    @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      exp_an = ((k % 8) < 2) ? 8'hFF : ~(8'h01 << (k / 8));
      checks++;
      if (an_b !== exp_an) begin
        failures++;
        $display("FAIL blank k=%0d: an=%h required %h", k, an_b, exp_an);
      end
    end
  endtask

  initial begin
    hexlut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    test_reset();
    test_hex_scan();
    test_raw_dp();
    test_pwm();
    test_mask();
    test_sync_irq();
    test_async_reset();
    test_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
